// File: rtl/fma_dot_sequencer.sv
// Dot-product sequencer for a shared single-issue FMA: streams operand pairs,
// feeds the running sum back through C, and aborts early to a canonical NaN.
module fma_dot_sequencer #(
  parameter int PARM_XLEN  = 32,
  parameter int PARM_EXP   = 8,
  parameter int PARM_MANT  = 23,
  parameter int PARM_LEN_W = 8
) (
  input  logic                  Clk_i,
  input  logic                  Rst_n_i,
  input  logic                  Start_i,
  input  logic [PARM_LEN_W-1:0] Len_i,
  output logic                  Busy_o,
  input  logic                  Op_Valid_i,
  output logic                  Op_Ready_o,
  input  logic [PARM_XLEN-1:0]  OpA_i,
  input  logic [PARM_XLEN-1:0]  OpB_i,
  output logic                  Fma_Valid_o,
  output logic [PARM_XLEN-1:0]  FmaA_o,
  output logic [PARM_XLEN-1:0]  FmaB_o,
  output logic [PARM_XLEN-1:0]  FmaC_o,
  input  logic                  Fma_Valid_i,
  input  logic [PARM_XLEN-1:0]  FmaRes_i,
  input  logic                  A_NaN_i,
  input  logic                  B_NaN_i,
  input  logic                  C_NaN_i,
  input  logic                  A_Inf_i,
  input  logic                  B_Inf_i,
  input  logic                  A_Zero_i,
  input  logic                  B_Zero_i,
  output logic                  Res_Valid_o,
  output logic [PARM_XLEN-1:0]  Res_o,
  output logic                  Res_Invalid_o
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DRAIN, DONE} state_t;

  localparam logic [PARM_LEN_W-1:0] LEN_ONE = {{(PARM_LEN_W-1){1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic [PARM_LEN_W-1:0]   rem, rem_nxt, rem_dec;
  logic [PARM_XLEN-1:0]    acc, acc_nxt;
  logic                    sticky, sticky_nxt;
  logic [PARM_XLEN-1:0]    fma_a_nxt, fma_b_nxt, fma_c_nxt;
  logic [PARM_XLEN-1:0]    res_nxt;
  logic                    res_inv_nxt;
  logic                    invalid;

  // Result is either the accumulator or the quiet canonical NaN.
  function automatic logic [PARM_XLEN-1:0] res_select(input logic inv,
                                                      input logic [PARM_XLEN-1:0] sum);
    logic [PARM_XLEN-1:0] nan;
    nan = {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};
    return inv ? nan : sum;
  endfunction

  assign invalid = A_NaN_i | B_NaN_i | C_NaN_i | (A_Inf_i & B_Zero_i) | (B_Inf_i & A_Zero_i);
  assign rem_dec = (rem != '0) ? rem - LEN_ONE : rem;

  assign Busy_o      = (state != IDLE);
  assign Op_Ready_o  = (state == FETCH) || (state == DRAIN);
  assign Fma_Valid_o = (state == ISSUE);
  assign Res_Valid_o = (state == DONE);

  always_comb begin
    state_nxt   = state;
    rem_nxt     = rem;
    acc_nxt     = acc;
    sticky_nxt  = sticky;
    fma_a_nxt   = FmaA_o;
    fma_b_nxt   = FmaB_o;
    fma_c_nxt   = FmaC_o;
    res_inv_nxt = Res_Invalid_o;
    unique case (state)
      IDLE: begin
        if (Start_i) begin
          rem_nxt     = Len_i;
          acc_nxt     = '0;
          sticky_nxt  = 1'b0;
          res_inv_nxt = 1'b0;
          state_nxt   = (Len_i == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (Op_Valid_i) begin
          fma_a_nxt = OpA_i;
          fma_b_nxt = OpB_i;
          fma_c_nxt = acc;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (invalid) begin
          sticky_nxt = 1'b1;
          rem_nxt    = rem_dec;
          state_nxt  = (rem_dec != '0) ? DRAIN : DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (Fma_Valid_i) begin
          acc_nxt   = FmaRes_i;
          rem_nxt   = rem_dec;
          state_nxt = (rem_dec == '0) ? DONE : FETCH;
        end
      end
      DRAIN: begin
        if (Op_Valid_i) begin
          rem_nxt   = rem_dec;
          state_nxt = (rem_dec == '0) ? DONE : DRAIN;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Load the result on entry to DONE so it is valid alongside Res_Valid_o.
    if (state_nxt == DONE && state != DONE) begin
      res_inv_nxt = sticky_nxt;
    end
    res_nxt = (state_nxt == DONE && state != DONE) ? res_select(sticky_nxt, acc_nxt) : Res_o;
  end

  always_ff @(posedge Clk_i) begin
    if (!Rst_n_i) begin
      state         <= IDLE;
      rem           <= '0;
      acc           <= '0;
      sticky        <= 1'b0;
      FmaA_o        <= '0;
      FmaB_o        <= '0;
      FmaC_o        <= '0;
      Res_o         <= '0;
      Res_Invalid_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      rem           <= rem_nxt;
      acc           <= acc_nxt;
      sticky        <= sticky_nxt;
      FmaA_o        <= fma_a_nxt;
      FmaB_o        <= fma_b_nxt;
      FmaC_o        <= fma_c_nxt;
      Res_o         <= res_nxt;
      Res_Invalid_o <= res_inv_nxt;
    end
  end

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Bench for fma_dot_sequencer: table vectors, corner sequences and random
// streams checked against a real-arithmetic dot-product model.
module tb_fma_dot_sequencer;

  logic        clk = 1'b0;
  logic        Rst_n_i = 1'b0;
  logic        Start_i = 1'b0;
  logic [7:0]  Len_i = '0;
  logic        Busy_o, Op_Ready_o, Fma_Valid_o, Res_Valid_o, Res_Invalid_o;
  logic        Op_Valid_i = 1'b0;
  logic [31:0] OpA_i = '0, OpB_i = '0;
  logic [31:0] FmaA_o, FmaB_o, FmaC_o, Res_o;
  logic        Fma_Valid_i = 1'b0;
  logic [31:0] FmaRes_i = '0;
  logic        A_NaN_i, B_NaN_i, C_NaN_i, A_Inf_i, B_Inf_i, A_Zero_i, B_Zero_i;

  always #5 clk = ~clk;

  fma_dot_sequencer dut (
    .Clk_i(clk), .Rst_n_i(Rst_n_i), .Start_i(Start_i), .Len_i(Len_i), .Busy_o(Busy_o),
    .Op_Valid_i(Op_Valid_i), .Op_Ready_o(Op_Ready_o), .OpA_i(OpA_i), .OpB_i(OpB_i),
    .Fma_Valid_o(Fma_Valid_o), .FmaA_o(FmaA_o), .FmaB_o(FmaB_o), .FmaC_o(FmaC_o),
    .Fma_Valid_i(Fma_Valid_i), .FmaRes_i(FmaRes_i),
    .A_NaN_i(A_NaN_i), .B_NaN_i(B_NaN_i), .C_NaN_i(C_NaN_i), .A_Inf_i(A_Inf_i),
    .B_Inf_i(B_Inf_i), .A_Zero_i(A_Zero_i), .B_Zero_i(B_Zero_i),
    .Res_Valid_o(Res_Valid_o), .Res_o(Res_o), .Res_Invalid_o(Res_Invalid_o)
  );

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction
  function automatic bit is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 0);
  endfunction
  function automatic bit is_zero(input logic [31:0] x);
    return x[30:0] == 0;
  endfunction

  // Special-case detector on the issued operands.
  assign A_NaN_i  = is_nan(FmaA_o);
  assign B_NaN_i  = is_nan(FmaB_o);
  assign C_NaN_i  = is_nan(FmaC_o);
  assign A_Inf_i  = is_inf(FmaA_o);
  assign B_Inf_i  = is_inf(FmaB_o);
  assign A_Zero_i = is_zero(FmaA_o);
  assign B_Zero_i = is_zero(FmaB_o);

  function automatic real f2r(input logic [31:0] x);
    real r;
    int  e;
    if (x[30:23] == 0) return 0.0;
    r = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return x[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    real         m;
    int          e;
    logic [31:0] fr;
    if (x == 0.0) return 32'h0;
    m = (x < 0.0) ? -x : x;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    fr = 32'($rtoi((m - 1.0) * 8388608.0));
    return {(x < 0.0), 8'(e), fr[22:0]};
  endfunction

  int errors = 0, checks = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Mock FMA with configurable latency; results land on the negedge.
  int          lat = 3;
  int          fma_cnt = 0;
  logic [31:0] fma_res = '0;
  int          cyc = 0, fv_cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    Fma_Valid_i = 1'b0;
    if (fma_cnt > 0) begin
      fma_cnt--;
      if (fma_cnt == 0) begin
        Fma_Valid_i = 1'b1;
        FmaRes_i    = fma_res;
        fv_cyc      = cyc;
      end
    end
    if (Fma_Valid_o) begin
      fma_res = r2f(f2r(FmaA_o) * f2r(FmaB_o) + f2r(FmaC_o));
      fma_cnt = lat;
    end
  end

  int          iss_cnt = 0, rdy_cnt = 0, hs_cnt = 0, res_cyc = 0;
  logic [31:0] c_seen[$];
  always @(negedge clk) begin
    if (Fma_Valid_o) begin iss_cnt++; c_seen.push_back(FmaC_o); end
    if (Op_Ready_o) rdy_cnt++;
  end

  logic [31:0] va[16], vb[16];

  task automatic run(input int len, input int stall_pct, input bit extra_start,
                     output logic [31:0] res, output bit inv, output int cycles);
    int idx = 0;
    bit done = 0;
    @(posedge clk); #1;
    iss_cnt = 0; rdy_cnt = 0; hs_cnt = 0; c_seen.delete();
    res = 'x; inv = 1'b0; cycles = 0;
    @(negedge clk);
    Start_i = 1'b1; Len_i = 8'(len);
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      cycles++;
      Start_i = 1'b0;
      if (Res_Valid_o) begin
        res = Res_o; inv = Res_Invalid_o; res_cyc = cyc; done = 1;
        Op_Valid_i = 1'b0;
      end else begin
        if (extra_start) begin
          Start_i = ($urandom_range(3) == 0);
          Len_i   = 8'($urandom);
        end
        Op_Valid_i = (idx < len) && (int'($urandom_range(99)) >= stall_pct);
        OpA_i = va[idx & 15]; OpB_i = vb[idx & 15];
        if (Op_Valid_i && Op_Ready_o) begin idx++; hs_cnt++; end
      end
    end
    Start_i = 1'b0;
    if (!done) check("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: dot product over the raw operand list, aborting on NaN or Inf*0.
  task automatic model(input int len, output logic [31:0] res, output bit inv, output int iss);
    real acc = 0.0;
    inv = 0; iss = len;
    for (int k = 0; k < len; k++) begin
      if (is_nan(va[k]) || is_nan(vb[k]) || (is_inf(va[k]) && is_zero(vb[k])) ||
          (is_inf(vb[k]) && is_zero(va[k]))) begin
        inv = 1; iss = k + 1;
        break;
      end
      acc = acc + f2r(va[k]) * f2r(vb[k]);
    end
    res = inv ? 32'h7FC00000 : r2f(acc);
  endtask

  typedef struct {
    int          len;
    logic [31:0] a0, a1, a2, b0, b1, b2;
    int          lat;
    logic [31:0] res;
    bit          inv;
    int          iss;
  } vec_t;

  logic [31:0] pool[6] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                           32'h3F000000, 32'hBF800000};

  initial begin
    vec_t        tbl[5];
    logic [31:0] res, eres, r2;
    bit          inv, einv, i2;
    int          cycles, eiss, c2, len;
    bit          bad;

    tbl[0] = '{2, 32'h3F800000, 32'h40400000, 0, 32'h40000000, 32'h3F800000, 0, 3, 32'h40A00000, 0, 2};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 3, 32'h00000000, 0, 0};
    tbl[2] = '{3, 32'h3F800000, 32'h7F800000, 32'h40000000, 32'h3F800000, 32'h00000000, 32'h40000000,
               2, 32'h7FC00000, 1, 2};
    tbl[3] = '{1, 32'h7FC00001, 0, 0, 32'h3F800000, 0, 0, 3, 32'h7FC00000, 1, 1};
    tbl[4] = '{3, 32'h3F000000, 32'h40000000, 32'hBF800000, 32'h40000000, 32'h40000000, 32'h40400000,
               1, 32'h40000000, 0, 3};

    repeat (3) @(negedge clk);
    check("rst_ctl", 32'({Busy_o, Op_Ready_o, Fma_Valid_o, Res_Valid_o, Res_Invalid_o}), 32'd0);
    check("rst_res", Res_o, 32'd0);
    check("rst_fma", FmaA_o | FmaB_o | FmaC_o, 32'd0);
    Rst_n_i = 1'b1;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      va[0] = tbl[i].a0; va[1] = tbl[i].a1; va[2] = tbl[i].a2;
      vb[0] = tbl[i].b0; vb[1] = tbl[i].b1; vb[2] = tbl[i].b2;
      lat = tbl[i].lat;
      run(tbl[i].len, 0, 0, res, inv, cycles);
      check($sformatf("tbl%0d_res", i), res, tbl[i].res);
      check($sformatf("tbl%0d_inv", i), 32'(inv), 32'(tbl[i].inv));
      check($sformatf("tbl%0d_issues", i), iss_cnt, tbl[i].iss);
      check($sformatf("tbl%0d_handshakes", i), hs_cnt, tbl[i].len);
      if (i == 0) begin
        check("tbl0_c0", (c_seen.size() > 0) ? c_seen[0] : 32'hDEADBEEF, 32'h00000000);
        check("tbl0_c1", (c_seen.size() > 1) ? c_seen[1] : 32'hDEADBEEF, 32'h40000000);
        check("tbl0_last_fv_to_res", res_cyc - fv_cyc, 1);
      end
      if (i == 1) begin
        check("len0_latency", cycles, 1);
        check("len0_no_ready", rdy_cnt, 0);
      end
      if (i == 3) begin
        bad = 0;
        repeat (6) begin
          @(negedge clk);
          if (Busy_o || Res_Valid_o) bad = 1;
        end
        check("nan_late_fma_ignored", 32'(bad), 32'd0);
      end
      idle(8);
    end

    // Reset during WAIT of a Len=4 run, with the FMA result arriving afterwards.
    lat = 5;
    @(negedge clk);
    Start_i = 1'b1; Len_i = 8'd4;
    @(negedge clk);
    Start_i = 1'b0;
    Op_Valid_i = 1'b1; OpA_i = 32'h3F800000; OpB_i = 32'h3F800000;
    bad = 1;
    for (int t = 0; t < 20 && bad; t++) begin
      @(negedge clk);
      if (Fma_Valid_o) bad = 0;
    end
    check("rstw_reached_issue", 32'(bad), 32'd0);
    Op_Valid_i = 1'b0;
    @(negedge clk);
    Rst_n_i = 1'b0;
    @(negedge clk);
    Rst_n_i = 1'b1;
    check("rstw_ctl", 32'({Busy_o, Op_Ready_o, Fma_Valid_o, Res_Valid_o, Res_Invalid_o}), 32'd0);
    check("rstw_res", Res_o, 32'd0);
    check("rstw_fma", FmaA_o | FmaB_o | FmaC_o, 32'd0);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (Busy_o || Res_Valid_o) bad = 1;
    end
    check("rstw_result_ignored", 32'(bad), 32'd0);
    lat = 2;
    va[0] = 32'h40000000; vb[0] = 32'h40400000;
    run(1, 0, 0, res, inv, cycles);
    check("rstw_rerun_res", res, 32'h40C00000);
    check("rstw_rerun_c0", (c_seen.size() > 0) ? c_seen[0] : 32'hDEADBEEF, 32'h00000000);
    idle(8);

    // Random streams: clean run, then stalled run with stray Start pulses.
    for (int n = 0; n < 15; n++) begin
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        va[k] = pool[$urandom_range(5)];
        vb[k] = pool[$urandom_range(5)];
        if ($urandom_range(9) == 0) begin
          case ($urandom_range(3))
            0: va[k] = 32'h7FC00000;
            1: vb[k] = 32'h7F800001;
            2: begin va[k] = 32'h7F800000; vb[k] = 32'h00000000; end
            default: begin va[k] = 32'h00000000; vb[k] = 32'hFF800000; end
          endcase
        end
      end
      lat = $urandom_range(1, 4);
      model(len, eres, einv, eiss);
      run(len, 0, 0, res, inv, cycles);
      check($sformatf("rnd%0d_res", n), res, eres);
      check($sformatf("rnd%0d_inv", n), 32'(inv), 32'(einv));
      check($sformatf("rnd%0d_issues", n), iss_cnt, eiss);
      idle(8);
      run(len, 40, 1, r2, i2, c2);
      check($sformatf("rnd%0d_stall_res", n), r2, eres);
      check($sformatf("rnd%0d_stall_inv", n), 32'(i2), 32'(einv));
      check($sformatf("rnd%0d_stall_hs", n), hs_cnt, len);
      check($sformatf("rnd%0d_stall_issues", n), iss_cnt, eiss);
      idle(8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
